bp_uce_mem_responder: RTL



---
 rtl/bp_uce_mem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bp_uce_mem_responder.sv
// Memory-side responder for UCE memory commands: block-addressed storage, one
// command outstanding, response returned after latency_p extra cycles.

module bp_uce_mem_byte_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic [7:0] rd_byte,
  input  logic       we,
  input  logic       keep,
  output logic [7:0] merged,
  output logic [7:0] rd_out
);
  assign merged = we   ? new_byte : old_byte;
  assign rd_out = keep ? rd_byte  : 8'h00;
endmodule

module bp_uce_mem_responder #(
  parameter  int paddr_width_p     = 40,
  parameter  int cce_block_width_p = 512,
  parameter  int lce_id_width_p    = 4,
  parameter  int lce_assoc_p       = 8,
  parameter  int mem_els_p         = 256,
  parameter  int latency_p         = 2,
  localparam int way_id_width_lp   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + 4 + way_id_width_lp
                                      + lce_id_width_p + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);
  localparam int NB    = cce_block_width_p / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(mem_els_p);

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_wr    = 4'd1,
    e_mem_uc_rd = 4'd2,
    e_mem_uc_wr = 4'd3,
    e_mem_wb    = 4'd4
  } msg_type_e;

  typedef struct packed {
    logic [2:0]                 state;
    logic                       speculative;
    logic [way_id_width_lp-1:0] way_id;
    logic [lce_id_width_p-1:0]  lce_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    logic [3:0]                   msg_type;
    logic [paddr_width_p-1:0]     addr;
    logic [2:0]                   size;
    bp_cce_mem_payload_s          payload;
    logic [cce_block_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e                       state, state_n;
  logic [7:0]                   cnt, cnt_n;
  bp_cce_mem_msg_s              cmd_r, cmd_n, cmd_in, acc, resp;
  logic [cce_block_width_p-1:0] resp_data, resp_data_n;
  logic                         accept, entry;

  logic [cce_block_width_p-1:0] mem [mem_els_p];

  assign cmd_in          = bp_cce_mem_msg_s'(mem_cmd_i);
  assign mem_cmd_ready_o = reset_n_i & (state == e_ready);
  assign accept          = mem_cmd_v_i & mem_cmd_ready_o;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd_r;
    case (state)
      e_ready: if (accept) begin
        cmd_n   = cmd_in;
        cnt_n   = 8'(latency_p);
        state_n = (latency_p == 0) ? e_resp : e_wait;
      end
      e_wait: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd1) state_n = e_resp;
      end
      e_resp: if (mem_resp_yumi_i) state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  // Storage is touched only on the cycle that enters e_resp; with zero latency
  // that is the accept cycle, so the command comes straight from the input.
  assign entry = (state_n == e_resp) && (state != e_resp);
  assign acc   = (state == e_ready) ? cmd_in : cmd_r;

  logic [IDX_W-1:0]             idx;
  logic [OFF_W-1:0]             off_al;
  logic [OFF_W:0]               nbytes, nb_m1;
  logic [3:0]                   size_eff;
  logic [NB-1:0]                lo_mask, byte_we;
  logic                         is_wb, is_ucwr, mem_we;
  logic [cce_block_width_p-1:0] rd_blk, rd_shift, wr_src, wr_blk, uc_rd_data;

  assign idx      = acc.addr[OFF_W +: IDX_W];
  assign size_eff = ({1'b0, acc.size} > 4'(OFF_W)) ? 4'(OFF_W) : {1'b0, acc.size};
  assign nbytes   = (OFF_W+1)'(1) << size_eff;
  assign nb_m1    = nbytes - (OFF_W+1)'(1);
  assign off_al   = acc.addr[OFF_W-1:0] & ~nb_m1[OFF_W-1:0];
  // A shift by NB yields zero, so a full-block size gives an all-ones mask.
  assign lo_mask  = ~({NB{1'b1}} << nbytes);

  assign is_wb    = (acc.msg_type == e_mem_wb);
  assign is_ucwr  = (acc.msg_type == e_mem_uc_wr);
  assign mem_we   = entry & (is_wb | is_ucwr);

  assign rd_blk   = mem[idx];
  assign rd_shift = rd_blk >> {off_al, 3'b000};
  assign wr_src   = is_wb ? acc.data : (acc.data << {off_al, 3'b000});
  assign byte_we  = is_wb ? {NB{1'b1}} : (is_ucwr ? (lo_mask << off_al) : '0);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    bp_uce_mem_byte_lane u_lane (
      .old_byte (rd_blk[8*b +: 8]),
      .new_byte (wr_src[8*b +: 8]),
      .rd_byte  (rd_shift[8*b +: 8]),
      .we       (byte_we[b]),
      .keep     (lo_mask[b]),
      .merged   (wr_blk[8*b +: 8]),
      .rd_out   (uc_rd_data[8*b +: 8])
    );
  end

  always_comb begin
    resp_data_n = '0;
    case (acc.msg_type)
      e_mem_rd, e_mem_wr: resp_data_n = rd_blk;
      e_mem_uc_rd:        resp_data_n = uc_rd_data;
      default:            resp_data_n = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= e_ready;
      cnt       <= '0;
      cmd_r     <= '0;
      resp_data <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cmd_r <= cmd_n;
      if (entry) resp_data <= resp_data_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx] <= wr_blk;
  end

  always_comb begin
    resp      = cmd_r;
    resp.data = resp_data;
  end

  assign mem_resp_o   = resp;
  assign mem_resp_v_o = (state == e_resp);

  logic unused_bits;
  assign unused_bits = ^{acc.addr, acc.payload};
endmodule
